// File: rtl/fp32_pkg.sv
// Shared types, constants and operand classification for the sequenced FP32 multiplier.
package fp32_pkg;

  localparam int unsigned EXP_W    = 8;
  localparam int unsigned MANT_W   = 23;
  localparam int unsigned SIG_W    = MANT_W + 1;   // significand with hidden bit
  localparam int unsigned PROD_W   = 2 * SIG_W;    // full significand product
  localparam int unsigned EXPC_W   = 10;           // signed working exponent
  localparam int unsigned EXP_BIAS = 127;
  localparam int unsigned EXP_MAX  = 255;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    MUL,
    NORM,
    DONE
  } state_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp32_t;

  function automatic logic is_nan(input fp32_t x);
    return (x.exp == EXP_W'(EXP_MAX)) && (x.mant != '0);
  endfunction

  function automatic logic is_inf(input fp32_t x);
    return (x.exp == EXP_W'(EXP_MAX)) && (x.mant == '0);
  endfunction

  // Denormals are flushed, so any zero exponent counts as zero.
  function automatic logic is_zero(input fp32_t x);
    return x.exp == '0;
  endfunction

endpackage

// File: rtl/fp32_mul_iter.sv
// Iterative shift-add significand multiplier, BITS_PER_CYCLE multiplier bits per step.
// Ports: i_clk/i_rst clock and sync reset; i_start loads operands and clears the
// accumulator; i_step performs one iteration; o_prod is the accumulator;
// o_last_c is high while the final iteration is being performed.
module fp32_mul_iter
  import fp32_pkg::*;
#(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_step,
  input  logic [SIG_W-1:0]  i_mcand,
  input  logic [SIG_W-1:0]  i_mplier,
  output logic [PROD_W-1:0] o_prod,
  output logic              o_last_c
);

  localparam int unsigned ITERS = SIG_W / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam int unsigned IDX_W = $clog2(SIG_W);

  logic [PROD_W-1:0] acc_q, acc_d;
  logic [PROD_W-1:0] mcand_q, mcand_d;
  logic [SIG_W-1:0]  mplier_q, mplier_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PROD_W-1:0] pp_c;

  // Sum of the partial products selected by the low multiplier bits.
  always_comb begin
    pp_c = '0;
    for (int unsigned j = 0; j < BITS_PER_CYCLE; j++) begin
      if (mplier_q[IDX_W'(j)]) pp_c = pp_c + (mcand_q << j);
    end
  end

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (i_start) begin
      acc_d    = '0;
      mcand_d  = PROD_W'(i_mcand);
      mplier_d = i_mplier;
      cnt_d    = '0;
    end else if (i_step) begin
      acc_d    = acc_q + pp_c;
      mcand_d  = mcand_q << BITS_PER_CYCLE;
      mplier_d = mplier_q >> BITS_PER_CYCLE;
      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_prod   = acc_q;
  assign o_last_c = (cnt_q == CNT_W'(ITERS - 1));

endmodule

// File: rtl/fp32_mul_seq.sv
// Sequenced FP32 multiplier: captures an operand pair, short-circuits NaN/Inf/zero,
// otherwise runs an iterative significand multiply, normalises and rounds (RNE).
// Ports: i_clk/i_rst clock and sync active-high reset; i_valid/o_ready operand
// handshake with i_float_A/i_float_B; o_valid/i_ready result handshake with
// o_result and one-hot flags o_overflow/o_zero/o_NaN; o_busy while not idle.
// BITS_PER_CYCLE must divide 24 (1,2,3,4,6,8,12,24).
module fp32_mul_seq
  import fp32_pkg::*;
#(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_float_A,
  input  logic [31:0] i_float_B,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_result,
  output logic        o_overflow,
  output logic        o_zero,
  output logic        o_NaN,
  output logic        o_busy
);

  state_e state_q, state_d;
  fp32_t  a_q, a_d, b_q, b_d;
  logic signed [EXPC_W-1:0] exp_q, exp_d;
  logic [31:0] result_q, result_d;
  logic valid_q, valid_d;
  logic ovf_q, ovf_d, zero_q, zero_d, nan_q, nan_d;
  logic busy_q, busy_d;

  logic              start_c, step_c, last_c;
  logic [PROD_W-1:0] prod;
  logic              sign_c;

  logic signed [EXPC_W-1:0] exp_n_c;
  logic [MANT_W-1:0]        mant_n_c;
  logic [SIG_W-1:0]         mant_rnd_c;
  logic                     guard_c, sticky_c;
  logic                     norm_ovf_c, norm_zero_c;
  logic [31:0]              norm_res_c;

  fp32_mul_iter #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_iter (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_start  (start_c),
    .i_step   (step_c),
    .i_mcand  ({1'b1, a_q.mant}),
    .i_mplier ({1'b1, b_q.mant}),
    .o_prod   (prod),
    .o_last_c (last_c)
  );

  assign sign_c = a_q.sign ^ b_q.sign;

  // Normalise the product, round to nearest even, then clamp the exponent range.
  always_comb begin
    exp_n_c  = exp_q;
    mant_n_c = prod[45:23];
    guard_c  = prod[22];
    sticky_c = |prod[21:0];
    if (prod[47]) begin
      exp_n_c  = exp_q + 10'sd1;
      mant_n_c = prod[46:24];
      guard_c  = prod[23];
      sticky_c = |prod[22:0];
    end
    mant_rnd_c = {1'b0, mant_n_c} + SIG_W'(guard_c & (sticky_c | mant_n_c[0]));
    if (mant_rnd_c[MANT_W]) begin
      exp_n_c  = exp_n_c + 10'sd1;
      mant_n_c = '0;
    end else begin
      mant_n_c = mant_rnd_c[MANT_W-1:0];
    end
    norm_ovf_c  = (exp_n_c >= $signed(EXPC_W'(EXP_MAX)));
    norm_zero_c = !norm_ovf_c && (exp_n_c <= $signed(EXPC_W'(0)));
    if (norm_ovf_c)       norm_res_c = {sign_c, 8'hFF, 23'b0};
    else if (norm_zero_c) norm_res_c = {sign_c, 31'b0};
    else                  norm_res_c = {sign_c, exp_n_c[EXP_W-1:0], mant_n_c};
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    exp_d    = exp_q;
    result_d = result_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    nan_d    = nan_q;
    start_c  = 1'b0;
    step_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          a_d     = i_float_A;
          b_d     = i_float_B;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (is_nan(a_q) || is_nan(b_q) ||
            (is_inf(a_q) && is_zero(b_q)) || (is_inf(b_q) && is_zero(a_q))) begin
          result_d = QNAN;
          nan_d    = 1'b1;
          valid_d  = 1'b1;
          state_d  = DONE;
        end else if (is_inf(a_q) || is_inf(b_q)) begin
          result_d = {sign_c, 8'hFF, 23'b0};
          ovf_d    = 1'b1;
          valid_d  = 1'b1;
          state_d  = DONE;
        end else if (is_zero(a_q) || is_zero(b_q)) begin
          result_d = {sign_c, 31'b0};
          zero_d   = 1'b1;
          valid_d  = 1'b1;
          state_d  = DONE;
        end else begin
          start_c = 1'b1;
          exp_d   = $signed(EXPC_W'(a_q.exp)) + $signed(EXPC_W'(b_q.exp))
                    - $signed(EXPC_W'(EXP_BIAS));
          state_d = MUL;
        end
      end
      MUL: begin
        step_c = 1'b1;
        if (last_c) state_d = NORM;
      end
      NORM: begin
        result_d = norm_res_c;
        ovf_d    = norm_ovf_c;
        zero_d   = norm_zero_c;
        valid_d  = 1'b1;
        state_d  = DONE;
      end
      DONE: begin
        if (i_ready) begin
          valid_d = 1'b0;
          ovf_d   = 1'b0;
          zero_d  = 1'b0;
          nan_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      exp_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      nan_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      exp_q    <= exp_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      nan_q    <= nan_d;
      busy_q   <= busy_d;
    end
  end

  // Ready must drop while reset is held, even before the reset edge.
  assign o_ready    = (state_q == IDLE) && !i_rst;
  assign o_valid    = valid_q;
  assign o_result   = result_q;
  assign o_overflow = ovf_q;
  assign o_zero     = zero_q;
  assign o_NaN      = nan_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_fp32_mul_seq.sv
// Self-checking bench for fp32_mul_seq: arithmetic reference model, per-cycle compare.
module tb_fp32_mul_seq;

  localparam int unsigned BPC   = 1;
  localparam int unsigned ITERS = 24 / BPC;
  localparam int          NV    = 15;

  logic        clk;
  logic        i_rst, i_valid, o_ready, o_valid, i_ready;
  logic [31:0] i_float_A, i_float_B, o_result;
  logic        o_overflow, o_zero, o_NaN, o_busy;

  fp32_mul_seq #(.BITS_PER_CYCLE(BPC)) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_float_A  (i_float_A),
    .i_float_B  (i_float_B),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_result   (o_result),
    .o_overflow (o_overflow),
    .o_zero     (o_zero),
    .o_NaN      (o_NaN),
    .o_busy     (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flags packed as {nan, zero, overflow}
  typedef struct {
    logic [31:0] res;
    logic [2:0]  flags;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, want, $time);
    end
  endtask

  // Reference: exact integer product of the significands, rounded by remainder compare.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    int ea, eb, e, sh;
    logic s;
    bit an, ai, az, bn, bi, bz;
    longint unsigned p, q, rem, half;
    ea = int'({24'd0, a[30:23]});
    eb = int'({24'd0, b[30:23]});
    s  = a[31] ^ b[31];
    an = (ea == 255) && (a[22:0] != 0);
    ai = (ea == 255) && (a[22:0] == 0);
    az = (ea == 0);
    bn = (eb == 255) && (b[22:0] != 0);
    bi = (eb == 255) && (b[22:0] == 0);
    bz = (eb == 0);
    r.lat   = 2;
    r.flags = 3'b000;
    r.res   = 32'h0;
    if (an || bn || (ai && bz) || (bi && az)) begin
      r.res = 32'h7FC00000; r.flags = 3'b100;
    end else if (ai || bi) begin
      r.res = {s, 8'hFF, 23'h0}; r.flags = 3'b001;
    end else if (az || bz) begin
      r.res = {s, 31'h0}; r.flags = 3'b010;
    end else begin
      r.lat = int'(ITERS) + 3;
      p  = {40'd0, 1'b1, a[22:0]} * {40'd0, 1'b1, b[22:0]};
      sh = (p >= (64'd1 << 47)) ? 24 : 23;
      e  = ea + eb - 127 + (sh - 23);
      q    = p >> sh;
      rem  = p - (q << sh);
      half = 64'd1 << (sh - 1);
      if ((rem > half) || ((rem == half) && q[0])) q = q + 1;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        e = e + 1;
      end
      if (e >= 255) begin
        r.res = {s, 8'hFF, 23'h0}; r.flags = 3'b001;
      end else if (e <= 0) begin
        r.res = {s, 31'h0}; r.flags = 3'b010;
      end else begin
        r.res = {s, e[7:0], q[22:0]};
      end
    end
    return r;
  endfunction

  // Per-cycle compare of outputs against the expected-result queue.
  always @(negedge clk) begin
    if (!i_rst) begin
      chk("busy_vs_ready", 32'(o_busy), 32'(!o_ready));
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid got=%h expected=no result at %0t", o_result, $time);
        end else begin
          chk("result", o_result, exp_q[0].res);
          chk("flags", 32'({o_NaN, o_zero, o_overflow}), 32'(exp_q[0].flags));
          if (i_ready) void'(exp_q.pop_front());
        end
      end else begin
        chk("flags_idle", 32'({o_NaN, o_zero, o_overflow}), 32'h0);
      end
    end
  end

  // Called #1 after a posedge; returns #1 after a posedge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input bit wait_res);
    exp_t e;
    int   n;
    e = model(a, b);
    i_valid   = 1'b1;
    i_float_A = a;
    i_float_B = b;
    n = 0;
    while (!o_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!o_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout got=no ready expected=ready at %0t", $time);
      i_valid = 1'b0;
      return;
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
    i_valid   = 1'b0;
    i_float_A = $urandom();
    i_float_B = $urandom();
    if (wait_res) begin
      n = 1;
      while (!o_valid && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      chk("latency", 32'(n), 32'(e.lat));
    end
  endtask

  logic [31:0] va [NV] = '{32'h3FC00000, 32'h3F800001, 32'h3FFFFFFF, 32'h7FC00001, 32'h7F800000,
                           32'hFF800000, 32'h7F000000, 32'h00800000, 32'h80000000, 32'hC0400000,
                           32'h3F800001, 32'h00800000, 32'h20000000, 32'h3F800000, 32'h00400000};
  logic [31:0] vb [NV] = '{32'h40000000, 32'h3F800001, 32'h3FFFFFFF, 32'h3F800000, 32'h00000000,
                           32'h40000000, 32'h7F000000, 32'h00800000, 32'h3F800000, 32'h40400000,
                           32'h3FC00000, 32'h3F800000, 32'h1F800000, 32'h7F7FFFFF, 32'h7F800000};
  logic [31:0] vr [NV] = '{32'h40400000, 32'h3F800002, 32'h407FFFFE, 32'h7FC00000, 32'h7FC00000,
                           32'hFF800000, 32'h7F800000, 32'h00000000, 32'h80000000, 32'hC1100000,
                           32'h3FC00002, 32'h00800000, 32'h00000000, 32'h7F7FFFFF, 32'h7FC00000};
  logic [2:0]  vf [NV] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b100,
                           3'b001, 3'b001, 3'b010, 3'b010, 3'b000,
                           3'b000, 3'b000, 3'b010, 3'b000, 3'b100};

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout expected=finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    i_rst     = 1'b1;
    i_valid   = 1'b0;
    i_ready   = 1'b1;
    i_float_A = 32'h0;
    i_float_B = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(o_ready), 32'h0);
    chk("rst_valid", 32'(o_valid), 32'h0);
    chk("rst_result", o_result, 32'h0);
    chk("rst_flags", 32'({o_NaN, o_zero, o_overflow}), 32'h0);
    chk("rst_busy", 32'(o_busy), 32'h0);
    i_rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(o_ready), 32'h1);
    @(posedge clk); #1;

    // Directed vectors: literal expectations pin the model, the DUT is compared to it.
    for (int i = 0; i < NV; i++) begin
      e = model(va[i], vb[i]);
      chk("model_pin_res", e.res, vr[i]);
      chk("model_pin_flags", 32'(e.flags), 32'(vf[i]));
      send(va[i], vb[i], 1'b1);
    end
    e = model(32'h3FC00000, 32'h40000000);
    chk("model_pin_lat_norm", 32'(e.lat), 32'd27);
    e = model(32'h7FC00001, 32'h3F800000);
    chk("model_pin_lat_special", 32'(e.lat), 32'd2);

    // Normal-range operands with random significands.
    for (int i = 0; i < 12; i++) begin
      send({1'($urandom_range(0, 1)), 8'($urandom_range(64, 190)), 23'($urandom())},
           {1'($urandom_range(0, 1)), 8'($urandom_range(64, 190)), 23'($urandom())}, 1'b1);
    end

    // Backpressure: result held, second operand pair waits for IDLE.
    @(posedge clk); #1;
    i_ready = 1'b0;
    send(32'h40400000, 32'h40000000, 1'b1);
    fork
      send(32'h3FC00000, 32'h40000000, 1'b1);
      begin
        for (int k = 0; k < 5; k++) begin
          chk("bp_ready", 32'(o_ready), 32'h0);
          chk("bp_valid", 32'(o_valid), 32'h1);
          chk("bp_result", o_result, 32'h40C00000);
          @(posedge clk); #1;
        end
        i_ready = 1'b1;
      end
    join
    @(posedge clk); #1;

    // Reset in the middle of the multiply phase.
    send(32'h3FC00000, 32'h40000000, 1'b0);
    repeat (9) begin
      @(posedge clk); #1;
    end
    chk("mid_busy", 32'(o_busy), 32'h1);
    i_rst = 1'b1;
    exp_q.delete();
    #1;
    chk("rst_hold_ready", 32'(o_ready), 32'h0);
    @(posedge clk); #1;
    chk("abort_valid", 32'(o_valid), 32'h0);
    chk("abort_busy", 32'(o_busy), 32'h0);
    i_rst = 1'b0;
    #1;
    chk("abort_ready", 32'(o_ready), 32'h1);
    repeat (30) begin
      @(posedge clk); #1;
    end
    send(32'h3FC00000, 32'h40000000, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
